// File: rtl/ir_pkg.sv
// Shared types and defaults for the IR receive path.
// Pulse classes, frame states and threshold constants.
package ir_pkg;

    typedef enum logic {
        IDLE,
        DATA
    } state_t;

    typedef enum logic [1:0] {
        START,
        ONE,
        ZERO,
        GLITCH
    } pclass_t;

    localparam int LOW_MIN_DEF   = 4;
    localparam int HIGH_MIN_DEF  = 9;
    localparam int START_MIN_DEF = 14;
    localparam int CLK_HZ        = 10_000;

    // Thresholds are ordered, so the widest matching class wins.
    function automatic pclass_t classify(
        input logic [31:0] w,
        input int          lo,
        input int          hi,
        input int          st
    );
        pclass_t c;
        if (w >= 32'(st))      c = START;
        else if (w >= 32'(hi)) c = ONE;
        else if (w >= 32'(lo)) c = ZERO;
        else                   c = GLITCH;
        return c;
    endfunction

endpackage

// File: rtl/ir_pulse_classifier.sv
// Synchroniser, pulse-width measurement and classification.
// Emits one pulse_evt per falling edge of the synchronised input.
import ir_pkg::*;

module ir_pulse_classifier #(
    parameter int CW        = 5,
    parameter int LOW_MIN   = LOW_MIN_DEF,
    parameter int HIGH_MIN  = HIGH_MIN_DEF,
    parameter int START_MIN = START_MIN_DEF,
    parameter int GW        = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ir_signal,
    output logic          pulse_evt,
    output pclass_t       pulse_class,
    output logic [GW-1:0] gap_cnt
);

    logic          sync1;
    logic          ir_s;
    logic          ir_d;
    logic [CW-1:0] width;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            ir_s    <= 1'b0;
            ir_d    <= 1'b0;
            width   <= '0;
            gap_cnt <= '0;
        end else begin
            sync1 <= ir_signal;
            ir_s  <= sync1;
            ir_d  <= ir_s;
            // A rise starts a fresh count even after a one-cycle gap.
            if (ir_s) begin
                if (!ir_d)
                    width <= CW'(1);
                else if (width != '1)
                    width <= width + 1'b1;
            end else if (!ir_d) begin
                width <= '0;
            end
            if (ir_s)
                gap_cnt <= '0;
            else if (gap_cnt != '1)
                gap_cnt <= gap_cnt + 1'b1;
        end
    end

    assign pulse_evt   = ir_d & ~ir_s;
    assign pulse_class = classify(32'(width), LOW_MIN,
                                  HIGH_MIN, START_MIN);

endmodule

// File: rtl/ir_frame_controller.sv
// IR frame sequencer: start pulse plus N bits into one word,
// delivered over valid/ready with framing-error and overrun pulses.
import ir_pkg::*;

module ir_frame_controller #(
    parameter int N           = 32,
    parameter int CW          = 5,
    parameter int LOW_MIN     = LOW_MIN_DEF,
    parameter int HIGH_MIN    = HIGH_MIN_DEF,
    parameter int START_MIN   = START_MIN_DEF,
    parameter int GAP_TIMEOUT = 30
) (
    input  logic         IR_READER_CLK,
    input  logic         reset,
    input  logic         ir_signal,
    output logic [N-1:0] frame_data,
    output logic         frame_valid,
    input  logic         frame_ready,
    output logic         busy,
    output logic         frame_err,
    output logic         overrun
);

    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam int BW = $clog2(N + 1);

    logic          pulse_evt;
    pclass_t       pclass;
    logic [GW-1:0] gap_cnt;
    state_t        state;
    logic [N-1:0]  sr;
    logic [BW-1:0] bit_cnt;
    logic [N-1:0]  word;
    logic          last;

    ir_pulse_classifier #(
        .CW        (CW),
        .LOW_MIN   (LOW_MIN),
        .HIGH_MIN  (HIGH_MIN),
        .START_MIN (START_MIN),
        .GW        (GW)
    ) u_cls (
        .clk         (IR_READER_CLK),
        .reset       (reset),
        .ir_signal   (ir_signal),
        .pulse_evt   (pulse_evt),
        .pulse_class (pclass),
        .gap_cnt     (gap_cnt)
    );

    assign word = {sr[N-2:0], pclass == ONE};
    assign last = bit_cnt == BW'(N - 1);
    assign busy = state == DATA;

    always_ff @(posedge IR_READER_CLK or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sr          <= '0;
            bit_cnt     <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (frame_valid && frame_ready)
                frame_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pulse_evt && pclass == START) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        sr      <= '0;
                    end
                end
                DATA: begin
                    if (pulse_evt) begin
                        unique case (pclass)
                            START: begin
                                bit_cnt <= '0;
                                sr      <= '0;
                            end
                            GLITCH: begin
                                state     <= IDLE;
                                frame_err <= 1'b1;
                            end
                            ONE, ZERO: begin
                                sr      <= word;
                                bit_cnt <= bit_cnt + 1'b1;
                                if (last) begin
                                    state <= IDLE;
                                    // Accept and reload may share an edge.
                                    if (!frame_valid || frame_ready) begin
                                        frame_data  <= word;
                                        frame_valid <= 1'b1;
                                    end else begin
                                        overrun <= 1'b1;
                                    end
                                end
                            end
                        endcase
                    end else if (gap_cnt >= GW'(GAP_TIMEOUT)) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ir_frame_controller.md
Name: ir_frame_controller

Overview:
Sequencer for the IR receive path. Synchronises the raw IR input, measures each high-pulse width on the 10 kHz reader clock and classifies it as start, one, zero or glitch. Frames a start pulse plus N data bits into a word and hands the word to the main top module over a valid/ready handshake. Also reports framing errors and dropped frames (overruns).

Parameters:
N, 32, data bits per frame (N >= 2)
CW, 5, width-counter bits; counter saturates at 2^CW-1
LOW_MIN, 4, minimum width in cycles for a zero bit
HIGH_MIN, 9, minimum width in cycles for a one bit
START_MIN, 14, minimum width in cycles for a start pulse (LOW_MIN < HIGH_MIN < START_MIN <= 2^CW-1)
GAP_TIMEOUT, 30, low cycles allowed between pulses inside a frame

Ports:
IR_READER_CLK  in  1  10 kHz reader clock
reset  in  1  asynchronous, active-low reset (0 = reset)
ir_signal  in  1  raw IR input, asynchronous, high = pulse
frame_data  out  N  completed frame, MSB = first received bit
frame_valid  out  1  frame_data holds an unread frame
frame_ready  in  1  consumer accepts frame_data when frame_valid & frame_ready
busy  out  1  high while a frame is being received (state DATA)
frame_err  out  1  one-cycle pulse: frame aborted
overrun  out  1  one-cycle pulse: completed frame dropped

Behaviour:
- Reset (reset=0, async) clears everything:
  - frame_data=0, frame_valid=0, busy=0, frame_err=0, overrun=0
  - sync flops=0, width count=0, bit count=0, shift register=0, state=IDLE
- Synchroniser: 2-flop sync gives ir_s; ir_d is ir_s delayed one cycle. Fall cycle F: ir_d=1 & ir_s=0.
- Width counter:
  - Increments each cycle ir_s=1, saturating at 2^CW-1.
  - Holds its value in cycle F, then clears to 0 in the next cycle ir_s=0.
  - Width w = count seen in cycle F, i.e. the number of cycles ir_s was high.
- Classification in cycle F:
  - w >= START_MIN: START
  - w >= HIGH_MIN: ONE
  - w >= LOW_MIN: ZERO
  - otherwise: GLITCH
- Gap counter: counts consecutive ir_s=0 cycles and clears when ir_s=1.
- FSM states IDLE and DATA; busy = (state==DATA).
- IDLE:
  - START: go to DATA, bit count=0, shift register=0.
  - ONE, ZERO or GLITCH: ignored.
- DATA:
  - ONE or ZERO: shift register <= {sr[N-2:0], bit}, bit count++.
  - On the N-th bit: return to IDLE and deliver the word {sr[N-2:0], bit}.
  - START: restart the frame (bit count=0, shift register=0), stay in DATA, no error.
  - GLITCH: go to IDLE and pulse frame_err.
  - Gap counter reaches GAP_TIMEOUT: go to IDLE and pulse frame_err.
- Delivery (frame completes in cycle F):
  - If frame_valid=0, or frame_valid=1 & frame_ready=1 in cycle F: frame_data loads at the F edge and frame_valid=1 from cycle F+1. Simultaneous accept and load leaves frame_valid=1 with the new data.
  - Otherwise: the new frame is dropped, the old data is held, and overrun pulses in cycle F+1.
- Handshake:
  - frame_valid drops the cycle after the accept, unless a new frame loads at the same edge.
  - frame_data is stable while frame_valid=1 and unaccepted.
- Latency: from the first raw low sample of the final pulse to frame_valid=1 is 3 clock edges (2 sync + 1 register).
- frame_err and overrun are registered, exactly one cycle wide, and never assert together.
- Saturated width is classified as START. A pulse held high forever produces no fall, so the FSM waits; no timeout applies while high.
- Reset mid-frame: the partial frame is discarded and a pending frame_valid is cleared.

Decomposition:
- Shared package ir_pkg: state enum (IDLE, DATA), pulse-class enum (START, ONE, ZERO, GLITCH), default thresholds (4/9/14) and the 10 kHz clock constant.
- Sub-module ir_pulse_classifier: synchroniser, fall detect, width counter, classifier. Outputs a one-cycle pulse_evt plus the 2-bit class, and gap_cnt.
- The FSM, shift register and output handshake live in ir_frame_controller.

Test Plan:
- N=8. Start 15 high, then bits 1,0,1,0,0,1,0,1 (ONE=10 high, ZERO=5 high), 3 low cycles between pulses, frame_ready=1 -> frame_data=0xA5, frame_valid high one cycle at fall+3, busy=0 afterwards, no err/overrun.
- Same frame with frame_ready=0, then a second frame 0x3C -> frame_data stays 0xA5, overrun pulses once. Then frame_ready=1 -> valid drops next cycle.
- Start then 3 bits, then a 2-cycle glitch pulse -> frame_err one cycle, busy=0, frame_valid stays 0. A following good frame 0x5A is received correctly.
- Start, 4 bits, then ir_signal low for 35 cycles -> frame_err at gap=30, state IDLE.
- Start, 2 bits, start again, 8 bits 0xFF -> frame_data=0xFF with no error. Pulses of widths 4/8/9/13/14 classify as ZERO/ZERO/ONE/ONE/START.
- reset=0 asserted mid-frame and while frame_valid=1 -> all outputs 0 immediately (async), and the next full frame decodes correctly.
